// File: rtl/cpu_pkg.sv
// Core-wide architectural widths shared by the fetch and decode stages.
package cpu_pkg;

    localparam int unsigned PIPE_WIDTH    = 2;
    localparam int unsigned CPU_ADDR_BITS = 32;
    localparam int unsigned CPU_INST_BITS = 32;

endpackage

// File: rtl/uarch_pkg.sv
// Microarchitecture sizing and payload types for the front end.
package uarch_pkg;

    import cpu_pkg::*;

    localparam int unsigned IBUF_DEPTH_DEFAULT = 4;

    // One buffer slot: a fetch pair of PCs plus its raw instruction words.
    typedef struct packed {
        logic [PIPE_WIDTH-1:0][CPU_ADDR_BITS-1:0] pcs;
        logic [PIPE_WIDTH-1:0][CPU_INST_BITS-1:0] insts;
    } ibuf_entry_t;

endpackage

// File: rtl/inst_buffer.sv
// Instruction-pair FIFO between the icache and decode.
// Optional IBUF_BYPASS_EN lets an empty buffer forward the incoming pair combinationally.
module inst_buffer
    import cpu_pkg::*;
    import uarch_pkg::*;
#(
    parameter int unsigned IBUF_DEPTH = IBUF_DEPTH_DEFAULT
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     flush,
    input  logic                                     icache_val,
    output logic                                     icache_rdy,
    input  logic [PIPE_WIDTH-1:0][CPU_ADDR_BITS-1:0] icache_pcs,
    input  logic [PIPE_WIDTH-1:0][CPU_INST_BITS-1:0] icache_insts,
    input  logic                                     decode_rdy,
    output logic                                     fetch_val,
    output logic [PIPE_WIDTH-1:0][CPU_ADDR_BITS-1:0] inst_pcs,
    output logic [PIPE_WIDTH-1:0][CPU_INST_BITS-1:0] insts,
    output logic [$clog2(IBUF_DEPTH+1)-1:0]          ibuf_count
);

    localparam int unsigned PTR_W = $clog2(IBUF_DEPTH);
    localparam int unsigned CNT_W = $clog2(IBUF_DEPTH+1);

    logic [PTR_W-1:0]                  r_head;
    logic [PTR_W-1:0]                  r_tail;
    logic [CNT_W-1:0]                  r_count;
    ibuf_entry_t [IBUF_DEPTH-1:0]      r_mem;

    ibuf_entry_t w_head_entry;
    ibuf_entry_t w_wr_entry;
    logic        w_empty;
    logic        w_enq;
    logic        w_deq;

    assign w_head_entry     = r_mem[r_head];
    assign w_wr_entry.pcs   = icache_pcs;
    assign w_wr_entry.insts = icache_insts;
    assign w_empty          = (r_count == '0);

    // A full buffer refuses new pairs even if decode drains one this cycle.
    assign icache_rdy = (r_count < CNT_W'(IBUF_DEPTH));
    assign ibuf_count = r_count;
    assign w_deq      = !w_empty && decode_rdy;

`ifdef IBUF_BYPASS_EN
    logic w_bypass;

    // Empty buffer forwards the fetch response; it is stored only if decode stalls.
    assign w_bypass  = w_empty && icache_val;
    assign fetch_val = !w_empty || icache_val;
    assign inst_pcs  = w_bypass ? icache_pcs   : w_head_entry.pcs;
    assign insts     = w_bypass ? icache_insts : w_head_entry.insts;
    assign w_enq     = icache_val && icache_rdy && !(w_bypass && decode_rdy);
`else
    assign fetch_val = !w_empty;
    assign inst_pcs  = w_head_entry.pcs;
    assign insts     = w_head_entry.insts;
    assign w_enq     = icache_val && icache_rdy;
`endif

    // Pointer/occupancy update; flush beats any same-cycle enqueue or dequeue.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_mem   <= '0;
        end else if (flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_enq) begin
                r_mem[r_tail] <= w_wr_entry;
                r_tail        <= r_tail + PTR_W'(1);
            end
            if (w_deq) begin
                r_head <= r_head + PTR_W'(1);
            end
            case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_inst_buffer.sv
// Directed self-checking bench for inst_buffer at IBUF_DEPTH=4.
module tb_inst_buffer;

    import cpu_pkg::*;

    logic                                     clk;
    logic                                     rst;
    logic                                     flush;
    logic                                     icache_val;
    logic                                     icache_rdy;
    logic [PIPE_WIDTH-1:0][CPU_ADDR_BITS-1:0] icache_pcs;
    logic [PIPE_WIDTH-1:0][CPU_INST_BITS-1:0] icache_insts;
    logic                                     decode_rdy;
    logic                                     fetch_val;
    logic [PIPE_WIDTH-1:0][CPU_ADDR_BITS-1:0] inst_pcs;
    logic [PIPE_WIDTH-1:0][CPU_INST_BITS-1:0] insts;
    logic [2:0]                               ibuf_count;

    int errors = 0;
    int checks = 0;

    inst_buffer #(.IBUF_DEPTH(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .icache_val   (icache_val),
        .icache_rdy   (icache_rdy),
        .icache_pcs   (icache_pcs),
        .icache_insts (icache_insts),
        .decode_rdy   (decode_rdy),
        .fetch_val    (fetch_val),
        .inst_pcs     (inst_pcs),
        .insts        (insts),
        .ibuf_count   (ibuf_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] pair_pcs(input logic [31:0] pc);
        return {pc + 32'd4, pc};
    endfunction

    function automatic logic [63:0] pair_insts(input logic [31:0] pc);
        return {32'hB000_0000 ^ pc, 32'hA000_0000 ^ pc};
    endfunction

    task automatic set_pair(input logic [31:0] pc);
        icache_pcs[0]   = pc;
        icache_pcs[1]   = pc + 32'd4;
        icache_insts[0] = 32'hA000_0000 ^ pc;
        icache_insts[1] = 32'hB000_0000 ^ pc;
    endtask

    initial begin
        logic [15:0] pat;
        int          sent;
        int          rcvd;
        int          mcnt;
        int          cyc;
        logic        do_enq;
        logic        do_deq;

        rst        = 1'b1;
        flush      = 1'b0;
        icache_val = 1'b0;
        decode_rdy = 1'b0;
        set_pair(32'h0);
        #2;
        // Asynchronous reset state, before any clock edge.
        chk("rst_count", 64'(ibuf_count), 64'd0);
        chk("rst_fetch_val", 64'(fetch_val), 64'd0);
        chk("rst_icache_rdy", 64'(icache_rdy), 64'd1);
        chk("rst_inst_pcs", 64'(inst_pcs), 64'd0);
        chk("rst_insts", 64'(insts), 64'd0);
        tick();
        tick();
        rst = 1'b0;

        // Single pair: visible one cycle after enqueue.
        set_pair(32'h100);
        icache_val = 1'b1;
        #1;
`ifndef IBUF_BYPASS_EN
        chk("one_same_cycle_val", 64'(fetch_val), 64'd0);
`endif
        tick();
        icache_val = 1'b0;
        #1;
        chk("one_fetch_val", 64'(fetch_val), 64'd1);
        chk("one_inst_pcs", 64'(inst_pcs), 64'h0000_0104_0000_0100);
        chk("one_insts", 64'(insts), pair_insts(32'h100));
        chk("one_count", 64'(ibuf_count), 64'd1);
        tick();
        chk("one_hold_pcs", 64'(inst_pcs), 64'h0000_0104_0000_0100);

        flush = 1'b1;
        tick();
        flush = 1'b0;
        #1;
        chk("flush1_count", 64'(ibuf_count), 64'd0);

        // Five back-to-back offers into a 4-deep buffer with decode stalled.
        for (int i = 0; i < 5; i++) begin
            set_pair(32'h200 + 32'(8 * i));
            icache_val = 1'b1;
            #1;
            chk("fill_rdy", 64'(icache_rdy), (i < 4) ? 64'd1 : 64'd0);
            tick();
        end
        icache_val = 1'b0;
        #1;
        chk("full_count", 64'(ibuf_count), 64'd4);
        chk("full_rdy", 64'(icache_rdy), 64'd0);
        chk("full_head", 64'(inst_pcs), pair_pcs(32'h200));

        // Full: offer and drain in the same cycle -> only the drain happens.
        set_pair(32'h300);
        icache_val = 1'b1;
        decode_rdy = 1'b1;
        tick();
        icache_val = 1'b0;
        decode_rdy = 1'b0;
        #1;
        chk("full_deq_count", 64'(ibuf_count), 64'd3);
        chk("full_deq_rdy", 64'(icache_rdy), 64'd1);
        chk("full_deq_head", 64'(inst_pcs), pair_pcs(32'h208));
        decode_rdy = 1'b1;
        for (int i = 1; i < 4; i++) begin
            #1;
            chk("drain_order", 64'(inst_pcs), pair_pcs(32'h200 + 32'(8 * i)));
            tick();
        end
        decode_rdy = 1'b0;
        #1;
        chk("drain_count", 64'(ibuf_count), 64'd0);
        chk("drain_fetch_val", 64'(fetch_val), 64'd0);

        // Flush with a same-cycle offer drops everything including the new pair.
        for (int i = 0; i < 3; i++) begin
            set_pair(32'h400 + 32'(8 * i));
            icache_val = 1'b1;
            tick();
        end
        set_pair(32'h418);
        flush = 1'b1;
        #1;
        chk("flush_rdy_indep", 64'(icache_rdy), 64'd1);
        tick();
        flush      = 1'b0;
        icache_val = 1'b0;
        #1;
        chk("flush_count", 64'(ibuf_count), 64'd0);
        chk("flush_fetch_val", 64'(fetch_val), 64'd0);
        tick();
        chk("flush_dropped", 64'(ibuf_count), 64'd0);

        // Stream ten pairs with a fixed stall pattern against a count model.
        pat  = 16'b1011_0110_1000_0000;
        sent = 0;
        rcvd = 0;
        mcnt = 0;
        cyc  = 0;
        while (rcvd < 10 && cyc < 200) begin
            decode_rdy = pat[cyc % 16];
            icache_val = (sent < 10);
            set_pair(32'h100 + 32'(8 * sent));
            #1;
            chk("stream_rdy", 64'(icache_rdy), (mcnt < 4) ? 64'd1 : 64'd0);
            chk("stream_count", 64'(ibuf_count), 64'(mcnt));
            chk("stream_val", 64'(fetch_val), (mcnt != 0) ? 64'd1 : 64'd0);
            do_deq = (mcnt != 0) && decode_rdy;
            do_enq = icache_val && (mcnt < 4);
            if (do_deq) begin
                chk("stream_pcs", 64'(inst_pcs), pair_pcs(32'h100 + 32'(8 * rcvd)));
                chk("stream_insts", 64'(insts), pair_insts(32'h100 + 32'(8 * rcvd)));
            end
            tick();
            if (do_enq) begin
                sent++;
                mcnt++;
            end
            if (do_deq) begin
                rcvd++;
                mcnt--;
            end
            cyc++;
        end
        icache_val = 1'b0;
        decode_rdy = 1'b0;
        #1;
        chk("stream_done", 64'(rcvd), 64'd10);
        chk("stream_end_count", 64'(ibuf_count), 64'd0);

        // Empty buffer, offer with decode ready.
        set_pair(32'h500);
        icache_val = 1'b1;
        decode_rdy = 1'b1;
        #1;
`ifdef IBUF_BYPASS_EN
        chk("byp_fetch_val", 64'(fetch_val), 64'd1);
        chk("byp_inst_pcs", 64'(inst_pcs), pair_pcs(32'h500));
        tick();
        icache_val = 1'b0;
        decode_rdy = 1'b0;
        #1;
        chk("byp_count", 64'(ibuf_count), 64'd0);
`else
        chk("nobyp_fetch_val", 64'(fetch_val), 64'd0);
        tick();
        icache_val = 1'b0;
        decode_rdy = 1'b0;
        #1;
        chk("nobyp_count", 64'(ibuf_count), 64'd1);
        chk("nobyp_inst_pcs", 64'(inst_pcs), pair_pcs(32'h500));
        decode_rdy = 1'b1;
        tick();
        decode_rdy = 1'b0;
        #1;
        chk("nobyp_drained", 64'(ibuf_count), 64'd0);
`endif

        // Reset in the middle of operation, between clock edges.
        for (int i = 0; i < 2; i++) begin
            set_pair(32'h600 + 32'(8 * i));
            icache_val = 1'b1;
            tick();
        end
        icache_val = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_count", 64'(ibuf_count), 64'd0);
        chk("midrst_fetch_val", 64'(fetch_val), 64'd0);
        chk("midrst_inst_pcs", 64'(inst_pcs), 64'd0);
        chk("midrst_rdy", 64'(icache_rdy), 64'd1);
        tick();
        rst = 1'b0;
        set_pair(32'h700);
        icache_val = 1'b1;
        tick();
        icache_val = 1'b0;
        #1;
        chk("postrst_count", 64'(ibuf_count), 64'd1);
        chk("postrst_head", 64'(inst_pcs), pair_pcs(32'h700));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
